// File: rtl/data_sampler_pkg.sv
// -----------------------------------------------------------------------------
// data_sampler_pkg
// Shared types and constants for the data_sampler readout sequencer.
//   state_t       : sequencer states (ST_HDR is only reachable when the
//                   DATA_SAMPLER_READOUT_HEADER_EN macro is defined)
//   DEF_*         : default parameter values for data_sampler_readout_ctrl
//   HDR_*         : header word layout for the default widths
//   cnt_width()   : bits needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package data_sampler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_TRIG    = 3'd2,
    ST_READ    = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_FLUSH   = 3'd5,
    ST_HDR     = 3'd6
  } state_t;

  localparam int DEF_DOUT_WIDTH     = 32;
  localparam int DEF_NWORDS_WIDTH   = 16;
  localparam int DEF_TRIG_CYCLES    = 1;
  localparam int DEF_HOLDOFF_CYCLES = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_EVCNT_WIDTH    = 16;

  // Header word: {event count, word count}; word count occupies the low bits.
  localparam int HDR_NW_LSB = 0;
  localparam int HDR_EV_LSB = DEF_NWORDS_WIDTH;
  localparam int HDR_EV_W   = DEF_DOUT_WIDTH - DEF_NWORDS_WIDTH;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/readout_timeout_cnt.sv
// -----------------------------------------------------------------------------
// readout_timeout_cnt
// Clear/increment counter with a terminal flag; used for the TRIG width,
// holdoff and starvation timers. The count stops at LIMIT so it never wraps.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count up by one while below LIMIT
//   term     : count == LIMIT
// -----------------------------------------------------------------------------
module readout_timeout_cnt #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [WIDTH-1:0] cnt_q;

  assign term = (cnt_q == WIDTH'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !term) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/data_sampler_readout_ctrl.sv
// -----------------------------------------------------------------------------
// data_sampler_readout_ctrl
// Sequencer for data_sampler_fifo: pulses TRIG on START or an EXT_TRIG rising
// edge, drains NWORDS words from the sampler's FWFT DOUT FIFO into a
// valid/ready stream with LAST framing, then holds off before re-arming.
// Starvation timeout and ABORT both end in FLUSH, which discards whatever is
// left in the FIFO.
//
// Optional build macro: DATA_SAMPLER_READOUT_HEADER_EN
//   defined   : one header word {EVCNT, nw} is streamed before the data words
//   undefined : the stream carries data words only
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   START               run one event (or start a continuous run) from IDLE
//   CONTINUOUS          re-arm after holdoff instead of returning to IDLE
//   EXT_TRIG_EN         wait for an EXT_TRIG rising edge before TRIG
//   EXT_TRIG            external trigger level (CLK-synchronous)
//   ABORT               abandon the current event, flush the FIFO
//   NWORDS              words per event, latched at START
//   TRIG                trigger pulse to the sampler (registered)
//   FIFO_DOUT/EMPTY     sampler DOUT side (first-word-fall-through)
//   FIFO_RDEN           sampler DOUT read enable
//   M_DATA/VALID/LAST   stream output, M_READY stream back-pressure
//   BUSY                sequencer not idle
//   DONE                one-cycle pulse on normal event completion
//   TIMEOUT_ERR         sticky starvation flag, cleared by START
//   EVCNT               completed-event count (wraps)
// -----------------------------------------------------------------------------
module data_sampler_readout_ctrl
  import data_sampler_pkg::*;
#(
  parameter int DOUT_WIDTH     = DEF_DOUT_WIDTH,
  parameter int NWORDS_WIDTH   = DEF_NWORDS_WIDTH,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int EVCNT_WIDTH    = DEF_EVCNT_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic                    CONTINUOUS,
  input  logic                    EXT_TRIG_EN,
  input  logic                    EXT_TRIG,
  input  logic                    ABORT,
  input  logic [NWORDS_WIDTH-1:0] NWORDS,
  output logic                    TRIG,
  input  logic [DOUT_WIDTH-1:0]   FIFO_DOUT,
  input  logic                    FIFO_EMPTY,
  output logic                    FIFO_RDEN,
  output logic [DOUT_WIDTH-1:0]   M_DATA,
  output logic                    M_VALID,
  output logic                    M_LAST,
  input  logic                    M_READY,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    TIMEOUT_ERR,
  output logic [EVCNT_WIDTH-1:0]  EVCNT
);

  state_t                  state_q;
  logic                    trig_q;
  logic                    done_q;
  logic                    terr_q;
  logic                    ext_q;
  logic [NWORDS_WIDTH-1:0] nw_q;
  logic [NWORDS_WIDTH-1:0] wcnt_q;
  logic [EVCNT_WIDTH-1:0]  evcnt_q;

  logic                    m_valid;
  logic                    m_last;
  logic [DOUT_WIDTH-1:0]   m_data;
  logic                    rden;
  logic                    xfer;
  logic [NWORDS_WIDTH-1:0] nw_last;
  logic                    trig_term;
  logic                    hold_term;
  logic                    to_term;

  // Stream handshake: a word moves on every cycle where M_VALID && M_READY are
  // both high. M_VALID never waits for M_READY, and M_DATA/M_LAST are held
  // stable while M_VALID is high and M_READY is low (FWFT head does not move
  // because FIFO_RDEN only fires on a transfer).
  assign xfer    = m_valid & M_READY;
  assign nw_last = nw_q - NWORDS_WIDTH'(1);

`ifdef DATA_SAMPLER_READOUT_HEADER_EN
  localparam int HDR_EVW = DOUT_WIDTH - NWORDS_WIDTH;
  logic [DOUT_WIDTH-1:0] hdr_word;
  assign hdr_word = {HDR_EVW'(evcnt_q), nw_q};
`endif

  // TRIG width: term is high in the last TRIG cycle.
  readout_timeout_cnt #(
    .WIDTH (cnt_width(TRIG_CYCLES)),
    .LIMIT (TRIG_CYCLES - 1)
  ) u_trig_cnt (
    .clk  (CLK),
    .rst  (RESET),
    .clr  (state_q != ST_TRIG),
    .inc  (state_q == ST_TRIG),
    .term (trig_term)
  );

  // Holdoff: term is high in the last holdoff cycle.
  readout_timeout_cnt #(
    .WIDTH (cnt_width(HOLDOFF_CYCLES)),
    .LIMIT (HOLDOFF_CYCLES - 1)
  ) u_hold_cnt (
    .clk  (CLK),
    .rst  (RESET),
    .clr  (state_q != ST_HOLDOFF),
    .inc  (state_q == ST_HOLDOFF),
    .term (hold_term)
  );

  // Starvation: counts consecutive READ cycles without a transfer; term in the
  // TIMEOUT_CYCLES-th such cycle. Header and flush cycles are never counted.
  readout_timeout_cnt #(
    .WIDTH (cnt_width(TIMEOUT_CYCLES)),
    .LIMIT (TIMEOUT_CYCLES - 1)
  ) u_to_cnt (
    .clk  (CLK),
    .rst  (RESET),
    .clr  ((state_q != ST_READ) | xfer),
    .inc  (state_q == ST_READ),
    .term (to_term)
  );

  always_comb begin
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    rden    = 1'b0;
    case (state_q)
      ST_READ: begin
        m_valid = !FIFO_EMPTY;
        m_data  = FIFO_DOUT;
        m_last  = !FIFO_EMPTY && (wcnt_q == nw_last);
        rden    = !FIFO_EMPTY && M_READY;
      end
      ST_FLUSH: begin
        rden = !FIFO_EMPTY;
      end
`ifdef DATA_SAMPLER_READOUT_HEADER_EN
      ST_HDR: begin
        m_valid = 1'b1;
        m_data  = hdr_word;
        m_last  = (nw_q == '0);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      ext_q   <= 1'b0;
      nw_q    <= '0;
      wcnt_q  <= '0;
      evcnt_q <= '0;
    end else begin
      // Tracked in every state so a level already high on entry to ARMED
      // does not look like a fresh edge.
      ext_q  <= EXT_TRIG;
      done_q <= 1'b0;
      if (ABORT && (state_q != ST_IDLE) && (state_q != ST_FLUSH)) begin
        // A transfer in this cycle still happens combinationally; only the
        // completion bookkeeping (DONE, EVCNT) is skipped.
        state_q <= ST_FLUSH;
        trig_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (START) begin
              nw_q   <= NWORDS;
              terr_q <= 1'b0;
              if (EXT_TRIG_EN) begin
                state_q <= ST_ARMED;
              end else begin
                state_q <= ST_TRIG;
                trig_q  <= 1'b1;
              end
            end
          end
          ST_ARMED: begin
            if (EXT_TRIG && !ext_q) begin
              state_q <= ST_TRIG;
              trig_q  <= 1'b1;
            end
          end
          ST_TRIG: begin
            if (trig_term) begin
              trig_q <= 1'b0;
              wcnt_q <= '0;
`ifdef DATA_SAMPLER_READOUT_HEADER_EN
              state_q <= ST_HDR;
`else
              if (nw_q == '0) begin
                state_q <= ST_HOLDOFF;
                done_q  <= 1'b1;
                evcnt_q <= evcnt_q + EVCNT_WIDTH'(1);
              end else begin
                state_q <= ST_READ;
              end
`endif
            end
          end
`ifdef DATA_SAMPLER_READOUT_HEADER_EN
          ST_HDR: begin
            if (M_READY) begin
              if (nw_q == '0) begin
                state_q <= ST_HOLDOFF;
                done_q  <= 1'b1;
                evcnt_q <= evcnt_q + EVCNT_WIDTH'(1);
              end else begin
                state_q <= ST_READ;
              end
            end
          end
`endif
          ST_READ: begin
            if (xfer && m_last) begin
              state_q <= ST_HOLDOFF;
              done_q  <= 1'b1;
              evcnt_q <= evcnt_q + EVCNT_WIDTH'(1);
            end else if (xfer) begin
              wcnt_q <= wcnt_q + NWORDS_WIDTH'(1);
            end else if (to_term) begin
              state_q <= ST_FLUSH;
              terr_q  <= 1'b1;
            end
          end
          ST_HOLDOFF: begin
            if (hold_term) begin
              if (!CONTINUOUS) begin
                state_q <= ST_IDLE;
              end else if (EXT_TRIG_EN) begin
                state_q <= ST_ARMED;
              end else begin
                state_q <= ST_TRIG;
                trig_q  <= 1'b1;
              end
            end
          end
          ST_FLUSH: begin
            if (FIFO_EMPTY) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign TRIG        = trig_q;
  assign FIFO_RDEN   = rden;
  assign M_DATA      = m_data;
  assign M_VALID     = m_valid;
  assign M_LAST      = m_last;
  assign BUSY        = (state_q != ST_IDLE);
  assign DONE        = done_q;
  assign TIMEOUT_ERR = terr_q;
  assign EVCNT       = evcnt_q;

endmodule

// File: tb/tb_data_sampler_readout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_sampler_readout_ctrl
// Directed bench for data_sampler_readout_ctrl with default parameters
// (TRIG_CYCLES=1, HOLDOFF_CYCLES=16, TIMEOUT_CYCLES=1024). A small FWFT FIFO
// model feeds the DUT; a stream monitor compares every transferred word with
// the expected queue. Header expectations follow DATA_SAMPLER_READOUT_HEADER_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_sampler_readout_ctrl;

  localparam int DW = 32;
  localparam int NW = 16;
  localparam int EW = 16;
`ifdef DATA_SAMPLER_READOUT_HEADER_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, continuous, ext_trig_en, ext_trig, abort, m_ready;
  logic [NW-1:0] nwords;
  logic          trig, fifo_rden, m_valid, m_last, busy, done, timeout_err;
  logic [DW-1:0] fifo_dout, m_data;
  logic          fifo_empty;
  logic [EW-1:0] evcnt;

  data_sampler_readout_ctrl dut (
    .CLK         (clk),
    .RESET       (rst),
    .START       (start),
    .CONTINUOUS  (continuous),
    .EXT_TRIG_EN (ext_trig_en),
    .EXT_TRIG    (ext_trig),
    .ABORT       (abort),
    .NWORDS      (nwords),
    .TRIG        (trig),
    .FIFO_DOUT   (fifo_dout),
    .FIFO_EMPTY  (fifo_empty),
    .FIFO_RDEN   (fifo_rden),
    .M_DATA      (m_data),
    .M_VALID     (m_valid),
    .M_LAST      (m_last),
    .M_READY     (m_ready),
    .BUSY        (busy),
    .DONE        (done),
    .TIMEOUT_ERR (timeout_err),
    .EVCNT       (evcnt)
  );

  // ---------------- FWFT FIFO model ----------------
  logic [DW-1:0] mem [0:31];
  logic [31:0]   wr_ptr;
  logic [31:0]   rd_ptr = '0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = mem[rd_ptr[4:0]];
  always @(posedge clk) begin
    if (fifo_rden && !fifo_empty) rd_ptr <= rd_ptr + 32'd1;
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;
  int xfer_cnt = 0, last_cnt = 0, done_cnt = 0, trig_rise_cnt = 0;
  int extra_cnt = 0, rden_bad = 0, underflow = 0;
  logic chk_rden = 1'b0;
  logic trig_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[4:0]] = base + DW'(i);
      wr_ptr = wr_ptr + 32'd1;
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] w, input logic last);
    exp_q.push_back(w);
    exp_last_q.push_back(last);
  endtask

  task automatic push_hdr(input logic [15:0] ev, input logic [15:0] nw, input logic last);
`ifdef DATA_SAMPLER_READOUT_HEADER_EN
    push_exp({ev, nw}, last);
`else
    if (ev === 16'hxxxx && nw === 16'hxxxx && last === 1'bx) $display("unused header args");
`endif
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  // Stream monitor, sampled on the falling edge (inputs change after rising).
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        xfer_cnt++;
        if (m_last) last_cnt++;
        if (exp_q.size() > 0) begin
          check("stream_word", m_data, exp_q.pop_front());
          check("stream_last", m_last, exp_last_q.pop_front());
        end else begin
          extra_cnt++;
        end
      end
      if (done) done_cnt++;
      if (trig && !trig_prev) trig_rise_cnt++;
      trig_prev = trig;
      if (chk_rden && (fifo_rden !== (m_valid && m_ready))) rden_bad++;
      if (fifo_rden && fifo_empty) underflow++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int b_done, b_trig, b_last, b_xfer, n;
    rst = 1'b0; start = 1'b0; continuous = 1'b0; ext_trig_en = 1'b0;
    ext_trig = 1'b0; abort = 1'b0; nwords = '0; m_ready = 1'b0; wr_ptr = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_trig", trig, 0);
    check("rst_rden", fifo_rden, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_evcnt", evcnt, 0);
    check("rst_data", m_data, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // T1: 4 words, ready always high
    load(32'hA0, 4);
    push_hdr(16'd0, 16'd4, 1'b0);
    push_exp(32'hA0, 0); push_exp(32'hA1, 0); push_exp(32'hA2, 0); push_exp(32'hA3, 1);
    chk_rden = 1'b1; m_ready = 1'b1; nwords = 16'd4; start = 1'b1;
    #1 check("t1_trig_before", trig, 0);
    tick(); start = 1'b0;
    check("t1_trig_rise", trig, 1);
    check("t1_busy", busy, 1);
    tick();
    check("t1_trig_width", trig, 0);
    wait_done(20, "t1_done");
    check("t1_evcnt", evcnt, 1);
    repeat (15) tick();
    check("t1_holdoff_busy", busy, 1);
    tick();
    check("t1_idle", busy, 0);
    check("t1_exp_left", exp_q.size(), 0);
    check("t1_fifo_left", wr_ptr - rd_ptr, 0);

    // T2: same with ready toggling
    load(32'hB0, 4);
    push_hdr(16'd1, 16'd4, 1'b0);
    push_exp(32'hB0, 0); push_exp(32'hB1, 0); push_exp(32'hB2, 0); push_exp(32'hB3, 1);
    nwords = 16'd4; start = 1'b1;
    tick(); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      m_ready = ~m_ready;
      n++;
    end
    check("t2_done", done, 1);
    m_ready = 1'b1;
    check("t2_evcnt", evcnt, 2);
    check("t2_exp_left", exp_q.size(), 0);
    check("t2_fifo_left", wr_ptr - rd_ptr, 0);
    check("t2_rden_only_on_xfer", rden_bad, 0);
    chk_rden = 1'b0;
    wait_idle(30, "t2_idle");

    // T3: continuous, external trigger, three edges, level held high
    load(32'hC0, 6);
    push_hdr(16'd2, 16'd2, 1'b0); push_exp(32'hC0, 0); push_exp(32'hC1, 1);
    push_hdr(16'd3, 16'd2, 1'b0); push_exp(32'hC2, 0); push_exp(32'hC3, 1);
    push_hdr(16'd4, 16'd2, 1'b0); push_exp(32'hC4, 0); push_exp(32'hC5, 1);
    b_done = done_cnt; b_trig = trig_rise_cnt; b_last = last_cnt;
    continuous = 1'b1; ext_trig_en = 1'b1; ext_trig = 1'b0; nwords = 16'd2; start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    check("t3_armed_busy", busy, 1);
    check("t3_armed_no_trig", trig_rise_cnt - b_trig, 0);
    for (int i = 0; i < 3; i++) begin
      ext_trig = 1'b1;
      wait_done(40, "t3_done");
      if (i == 2) begin
        continuous = 1'b0;
      end else begin
        repeat (30) tick();
        check("t3_level_once_done", done_cnt - b_done, i + 1);
        check("t3_level_once_trig", trig_rise_cnt - b_trig, i + 1);
        ext_trig = 1'b0;
        tick();
      end
    end
    wait_idle(40, "t3_idle");
    ext_trig = 1'b0; ext_trig_en = 1'b0;
    check("t3_evcnt", evcnt, 5);
    check("t3_trig_rises", trig_rise_cnt - b_trig, 3);
    check("t3_lasts", last_cnt - b_last, 3);
    check("t3_exp_left", exp_q.size(), 0);

    // T0: NWORDS=0 with START and ABORT together in IDLE
    push_hdr(16'd5, 16'd0, 1'b1);
    b_xfer = xfer_cnt;
    nwords = 16'd0; start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    check("t0_start_wins", trig, 1);
    wait_done(10, "t0_done");
    check("t0_evcnt", evcnt, 6);
    check("t0_xfers", xfer_cnt - b_xfer, HDR_WORDS);
    wait_idle(30, "t0_idle");

    // T4: starvation timeout after 3 of 8 words
    load(32'hD0, 3);
    push_hdr(16'd6, 16'd8, 1'b0);
    push_exp(32'hD0, 0); push_exp(32'hD1, 0); push_exp(32'hD2, 0);
    b_xfer = xfer_cnt; b_done = done_cnt;
    nwords = 16'd8; m_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    n = 0;
    while ((xfer_cnt - b_xfer) < 3 + HDR_WORDS && n < 20) begin
      tick();
      n++;
    end
    check("t4_words_before_stall", xfer_cnt - b_xfer, 3 + HDR_WORDS);
    repeat (1023) tick();
    check("t4_no_err_yet", timeout_err, 0);
    check("t4_still_busy", busy, 1);
    tick();
    check("t4_timeout_err", timeout_err, 1);
    tick();
    check("t4_idle", busy, 0);
    check("t4_terr_sticky", timeout_err, 1);
    check("t4_evcnt", evcnt, 6);
    check("t4_no_done", done_cnt - b_done, 0);
    check("t4_exp_left", exp_q.size(), 0);

    // T5: abort after 2 of 8 words with 5 still buffered
    load(32'hE0, 7);
    push_hdr(16'd6, 16'd8, 1'b0);
    push_exp(32'hE0, 0); push_exp(32'hE1, 0);
    b_xfer = xfer_cnt; b_done = done_cnt; b_last = last_cnt;
    nwords = 16'd8; m_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check("t5_terr_cleared", timeout_err, 0);
    n = 0;
    while ((xfer_cnt - b_xfer) < 2 + HDR_WORDS && n < 20) begin
      tick();
      n++;
    end
    m_ready = 1'b0; abort = 1'b1;
    tick(); abort = 1'b0;
    check("t5_valid_dropped", m_valid, 0);
    check("t5_flush_rden", fifo_rden, 1);
    check("t5_fifo_buffered", wr_ptr - rd_ptr, 5);
    repeat (5) tick();
    check("t5_fifo_drained", wr_ptr - rd_ptr, 0);
    check("t5_busy_flush", busy, 1);
    tick();
    check("t5_idle", busy, 0);
    check("t5_no_last", last_cnt - b_last, 0);
    check("t5_no_done", done_cnt - b_done, 0);
    check("t5_evcnt", evcnt, 6);
    check("t5_exp_left", exp_q.size(), 0);

    // Asynchronous reset while a word is presented
    load(32'hF0, 2);
    m_ready = 1'b0; nwords = 16'd4; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    check("rr_valid_pre", m_valid, 1);
    check("rr_evcnt_pre", evcnt, 6);
    #2 rst = 1'b1;
    #1;
    check("rr_valid", m_valid, 0);
    check("rr_data", m_data, 0);
    check("rr_busy", busy, 0);
    check("rr_evcnt", evcnt, 0);
    check("rr_rden", fifo_rden, 0);
    check("rr_trig", trig, 0);
    tick();
    rst = 1'b0;
    wr_ptr = rd_ptr;
    tick();

    check("final_extra_words", extra_cnt, 0);
    check("final_underflow", underflow, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
